// File: rtl/tinyalu_arbiter.sv
// rtl/tinyalu_arbiter.sv - round-robin command arbiter and sequencer for one TinyALU
// Serialises requests onto the ALU, holds start until done, and returns tagged results.
module tinyalu_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ID_W       = 1,
  parameter int TIMEOUT    = 16,
  parameter int GAP_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  input  logic [3*NUM_REQ-1:0] req_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [15:0]          rsp_result,
  output logic                 rsp_err,
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  output logic [2:0]           alu_op,
  output logic                 alu_start,
  input  logic                 alu_done,
  input  logic [15:0]          alu_result,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, GAP} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr, grant_id, next_ptr;
  logic            grant_found, accept, used_alu, timeout_hit;
  logic [7:0]      g_a, g_b, cnt;
  logic [2:0]      g_op;

  // Scan offsets from rr_ptr so the first hit is the lowest index at or after it, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    g_a         = '0;
    g_b         = '0;
    g_op        = '0;
    req_ready   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!grant_found && req_valid[j] &&
            (int'(rr_ptr) + off == j || int'(rr_ptr) + off == j + NUM_REQ)) begin
          grant_found  = 1'b1;
          grant_id     = ID_W'(j);
          g_a          = req_a[8*j +: 8];
          g_b          = req_b[8*j +: 8];
          g_op         = req_op[3*j +: 3];
          req_ready[j] = (state == IDLE) && !reset;
        end
      end
    end
  end

  assign accept      = (state == IDLE) && grant_found && !reset;
  assign next_ptr    = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
  assign timeout_hit = (cnt == 8'(TIMEOUT - 1));

  assign rsp_valid = (state == RESP);
  assign alu_start = (state == ISSUE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (g_op == 3'b000) ? RESP : ISSUE;
      ISSUE:   if (alu_done || timeout_hit) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = used_alu ? GAP : IDLE;
      GAP:     if (cnt == 8'(GAP_CYCLES - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cnt        <= '0;
      used_alu   <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
    end else begin
      state <= state_nxt;
      // One counter serves both ISSUE timeout and GAP length; it clears on every state change.
      cnt   <= ((state == ISSUE || state == GAP) && state_nxt == state) ? cnt + 8'd1 : 8'd0;
      if (accept) begin
        rsp_id   <= grant_id;
        rr_ptr   <= next_ptr;
        used_alu <= (g_op != 3'b000);
        if (g_op == 3'b000) begin
          rsp_result <= '0;
          rsp_err    <= 1'b0;
        end else begin
          alu_a  <= g_a;
          alu_b  <= g_b;
          alu_op <= g_op;
        end
      end
      if (state == ISSUE) begin
        if (alu_done) begin
          rsp_result <= alu_result;
          rsp_err    <= 1'b0;
        end else if (timeout_hit) begin
          rsp_result <= '0;
          rsp_err    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// tb/tb_tinyalu_arbiter.sv - directed and randomized bench for tinyalu_arbiter
// Includes a behavioural TinyALU stand-in and a round-robin scoreboard.
module tb_tinyalu_arbiter;

  localparam int NUM_REQ    = 2;
  localparam int ID_W       = 1;
  localparam int TIMEOUT    = 16;
  localparam int GAP_CYCLES = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic [8*NUM_REQ-1:0] req_a = '0;
  logic [8*NUM_REQ-1:0] req_b = '0;
  logic [3*NUM_REQ-1:0] req_op = '0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b1;
  logic [ID_W-1:0]      rsp_id;
  logic [15:0]          rsp_result;
  logic                 rsp_err;
  logic [7:0]           alu_a, alu_b;
  logic [2:0]           alu_op;
  logic                 alu_start;
  logic                 alu_done;
  logic [15:0]          alu_result;
  logic                 busy;

  tinyalu_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
    if (op[2]) return 16'(a) * 16'(b);
    case (op[1:0])
      2'd1:    return 16'(a) + 16'(b);
      2'd2:    return {8'h00, a & b};
      2'd3:    return {8'h00, a ^ b};
      default: return 16'h0000;
    endcase
  endfunction

  // TinyALU stand-in: done after 2 start cycles (5 for multiply), plus stray done pulses after a multiply.
  bit         hang = 1'b0;
  bit         late = 1'b0;
  logic [7:0] scnt = '0;
  logic [1:0] trail = '0;
  logic       start_done;

  assign start_done = alu_start && !hang &&
                      (late ? (scnt == 8'(TIMEOUT - 1)) : (scnt == (alu_op[2] ? 8'd4 : 8'd1)));
  assign alu_done   = start_done || (trail != 2'd0);
  assign alu_result = (trail != 2'd0 && !start_done) ? 16'hDEAD : alu_fn(alu_a, alu_b, alu_op);

  always @(posedge clk) begin
    scnt <= (alu_start && !alu_done) ? scnt + 8'd1 : 8'd0;
    if (start_done && alu_op[2]) trail <= 2'd3;
    else if (trail != 2'd0) trail <= trail - 2'd1;
  end

  wire [41:0] outvec = {req_ready, rsp_valid, rsp_id, rsp_result, rsp_err,
                        alu_a, alu_b, alu_op, alu_start, busy};

  // Scoreboard: round-robin expectation, one command in flight, response payload and ALU usage.
  int              rr_m = 0, m_g, m_e, m_j, gap_left = 0, start_cnt = 0, p_start = 0;
  bit              pend = 1'b0, stall = 1'b0, p_err = 1'b0;
  logic [ID_W-1:0] p_id = '0;
  logic [2:0]      p_op = '0;
  logic [15:0]     p_res = '0;
  logic [17:0]     s_payload = '0;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset) begin
        rr_m = 0; pend = 0; stall = 0; gap_left = 0; start_cnt = 0;
      end else begin
        if (alu_start) start_cnt++;
        if (req_ready != '0) begin
          m_g = -1;
          m_e = -1;
          for (int i = 0; i < NUM_REQ; i++) if (m_g < 0 && req_ready[i]) m_g = i;
          for (int off = 0; off < NUM_REQ; off++) begin
            m_j = (rr_m + off) % NUM_REQ;
            if (m_e < 0 && req_valid[m_j]) m_e = m_j;
          end
          check("gap_hold", 64'(gap_left), 0);
          check("grant_onehot", 64'($countones(req_ready)), 1);
          check("grant_rr", 64'(m_g), 64'(m_e));
          check("grant_overlap", 64'(pend), 0);
          p_id    = ID_W'(m_g);
          p_op    = req_op[3*m_g +: 3];
          p_err   = hang && (p_op != 3'b000);
          p_res   = p_err ? 16'h0000 : alu_fn(req_a[8*m_g +: 8], req_b[8*m_g +: 8], p_op);
          p_start = (p_op == 3'b000) ? 0 : ((hang || late) ? TIMEOUT : (p_op[2] ? 5 : 2));
          pend      = 1;
          start_cnt = 0;
          rr_m      = (m_g + 1) % NUM_REQ;
        end
        if (gap_left > 0) gap_left--;
        if (rsp_valid) begin
          check("rsp_pending", 64'(pend), 1);
          if (stall) check("rsp_frozen", 64'({rsp_id, rsp_result, rsp_err}), 64'(s_payload));
          check("rsp_payload", 64'({rsp_id, rsp_result, rsp_err}), 64'({p_id, p_res, p_err}));
          check("alu_start_cycles", 64'(start_cnt), 64'(p_start));
          if (rsp_ready) begin
            pend  = 0;
            stall = 0;
            if (p_op != 3'b000) gap_left = GAP_CYCLES;
          end else begin
            stall     = 1;
            s_payload = {rsp_id, rsp_result, rsp_err};
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int idx, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input int exp_lat, input logic [15:0] exp_res,
                       input logic exp_err, output int wait_n);
    int k;
    bit got;
    req_a[8*idx +: 8]  = a;
    req_b[8*idx +: 8]  = b;
    req_op[3*idx +: 3] = op;
    req_valid[idx]     = 1'b1;
    wait_n = 0;
    got    = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      wait_n++;
      if (req_ready[idx]) got = 1;
    end
    check("grant_seen", 64'(got), 1);
    tick();
    req_valid[idx] = 1'b0;
    if (!got) return;
    k   = 0;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      k++;
      if (rsp_valid) got = 1;
    end
    check("rsp_latency", 64'(k), 64'(exp_lat));
    check("rsp_id", 64'(rsp_id), 64'(idx));
    check("rsp_result", 64'(rsp_result), 64'(exp_res));
    check("rsp_err", 64'(rsp_err), 64'(exp_err));
    tick();
  endtask

  initial begin : watchdog
    #500000;
    check("watchdog", 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin : stim
    int w, n, k, r, g;
    bit got;
    logic [NUM_REQ-1:0] gmask;

    req_valid = '1;
    repeat (3) tick();
    @(negedge clk);
    check("reset_outputs", 64'(outvec), 0);
    req_valid = '0;
    tick();
    reset = 1'b0;

    issue(0, 8'h12, 8'h34, 3'b001, 3, 16'h0046, 1'b0, w);
    issue(1, 8'hFF, 8'hFF, 3'b100, 6, 16'hFE01, 1'b0, w);
    check("gap_grant_wait", 64'(w), 64'(GAP_CYCLES + 1));
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n += int'(rsp_valid);
      tick();
    end
    check("mul_single_rsp", 64'(n), 0);

    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[8*i +: 8]  = 8'hA5;
      req_b[8*i +: 8]  = 8'h0F;
      req_op[3*i +: 3] = 3'b011;
    end
    req_valid = '1;
    k = 0;
    r = 0;
    for (int c = 0; c < 300 && r < 8; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        g = req_ready[1] ? 1 : 0;
        check("fair_order", 64'(g), 64'(k % 2));
        k++;
      end
      if (rsp_valid) begin
        check("fair_result", 64'(rsp_result), 64'h00AA);
        r++;
      end
      tick();
      if (k == 8) req_valid = '0;
    end
    check("fair_count", 64'(r), 8);
    req_valid = '0;

    req_a[7:0] = 8'h55;
    req_b[7:0] = 8'h66;
    req_op[2:0] = 3'b000;
    req_valid[0] = 1'b1;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (req_ready[0]) got = 1;
    end
    check("noop_grant", 64'(got), 1);
    tick();
    req_valid[0] = 1'b0;
    rsp_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n += int'(rsp_valid);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n += int'(rsp_valid);
    tick();
    @(negedge clk);
    check("noop_released", 64'(rsp_valid), 0);
    check("noop_hold_cycles", 64'(n), 6);
    tick();
    issue(1, 8'h01, 8'h02, 3'b000, 1, 16'h0000, 1'b0, w);
    issue(0, 8'h03, 8'h04, 3'b000, 1, 16'h0000, 1'b0, w);
    check("noop_next_grant", 64'(w), 1);

    hang = 1'b1;
    issue(0, 8'h12, 8'h34, 3'b001, 1 + TIMEOUT, 16'h0000, 1'b1, w);
    hang = 1'b0;
    late = 1'b1;
    issue(1, 8'h03, 8'h04, 3'b001, 1 + TIMEOUT, 16'h0007, 1'b0, w);
    late = 1'b0;
    repeat (GAP_CYCLES + 2) tick();

    req_a[7:0] = 8'h09;
    req_b[7:0] = 8'h07;
    req_op[2:0] = 3'b100;
    req_valid[0] = 1'b1;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (req_ready[0]) got = 1;
    end
    check("rstmul_grant", 64'(got), 1);
    tick();
    req_valid[0] = 1'b0;
    n = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n += int'(rsp_valid);
      tick();
    end
    reset = 1'b1;
    @(negedge clk);
    n += int'(rsp_valid);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rstmul_outputs", 64'(outvec), 0);
    check("rstmul_no_rsp", 64'(n), 0);
    tick();
    req_a[15:8] = 8'h21;
    req_b[15:8] = 8'h22;
    req_op[5:3] = 3'b010;
    req_op[2:0] = 3'b001;
    req_valid = '1;
    @(negedge clk);
    check("rst_first_grant", 64'(req_ready), 64'b01);
    tick();
    req_valid = '0;

    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      gmask = req_ready & req_valid;
      tick();
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gmask[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_a[8*i +: 8]  = 8'($urandom);
          req_b[8*i +: 8]  = 8'($urandom);
          req_op[3*i +: 3] = 3'($urandom_range(0, 7));
          req_valid[i]     = 1'b1;
        end
      end
    end
    @(negedge clk);
    gmask = req_ready & req_valid;
    tick();
    req_valid = '0;
    rsp_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (!busy && !pend) got = 1;
      else tick();
    end
    check("drain_busy", 64'(busy), 0);
    check("drain_pending", 64'(pend), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
